// File: rtl/cr16_datapath.sv
// cr16_datapath - CompactRISC16 execution datapath.
//   16 x 16-bit register file with two combinational read ports, an
//   immediate/ALU-result write mux, a 16-bit ALU and a registered flag
//   register {C,L,F,Z,N}.
// Ports:
//   I_CLK              clock, rising edge
//   I_NRESET           asynchronous reset, active HIGH (clears regs and flags)
//   I_ENABLE           global enable for register and flag updates
//   I_REG_ENABLE       one-hot (or multi-hot) register write enables
//   I_READ_PORT_A_SEL  operand A register select
//   I_READ_PORT_B_SEL  operand B register select
//   I_OPCODE           ALU operation
//   I_IMMEDIATE        immediate write value
//   I_IMM_SEL          1 = write immediate, 0 = write ALU result
//   O_WRITE_PORT       combinational write-back value
//   O_FLAGS            registered flags, bits [4:0] = {C,L,F,Z,N}
module cr16_datapath #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  localparam int SEL_W     = $clog2(NUM_REGS)
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_ENABLE,
  input  logic [NUM_REGS-1:0]   I_REG_ENABLE,
  input  logic [SEL_W-1:0]      I_READ_PORT_A_SEL,
  input  logic [SEL_W-1:0]      I_READ_PORT_B_SEL,
  input  logic [3:0]            I_OPCODE,
  input  logic [DATA_WIDTH-1:0] I_IMMEDIATE,
  input  logic                  I_IMM_SEL,
  output logic [DATA_WIDTH-1:0] O_WRITE_PORT,
  output logic [4:0]            O_FLAGS
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_ADDU = 4'b0001, OP_ADDC = 4'b0010, OP_SUBC = 4'b0011,
    OP_SUB  = 4'b0100, OP_CMP  = 4'b0101, OP_AND  = 4'b0110, OP_OR   = 4'b0111,
    OP_XOR  = 4'b1000, OP_NOT  = 4'b1001, OP_LSH  = 4'b1010, OP_ASH  = 4'b1011,
    OP_MOV  = 4'b1100, OP_LUI  = 4'b1101
  } op_t;

  // flag bit positions inside O_FLAGS
  localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [DATA_WIDTH-1:0] a, b, res;
  logic                  c_new, l_new, f_new, z_new, n_new;
  logic [DATA_WIDTH:0]   sum, diff;
  logic                  cin;
  logic [4:0]            sh_raw;
  logic [5:0]            sh_mag;

  // Reads are straight muxes: a register written this edge shows up after it.
  assign a = regs[I_READ_PORT_A_SEL];
  assign b = regs[I_READ_PORT_B_SEL];

  // Carry-in is only consumed by ADDC/SUBC; plain ADD/SUB/CMP ignore C.
  assign cin  = (I_OPCODE == OP_ADDC || I_OPCODE == OP_SUBC) ? O_FLAGS[FC] : 1'b0;
  assign sum  = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
  // Top bit of the extended difference is the borrow.
  assign diff = {1'b0, a} - {1'b0, b} - {{DATA_WIDTH{1'b0}}, cin};

  // Shift count is B[4:0] as a signed value: -16..+15. Negative = right.
  assign sh_raw = b[4:0];
  assign sh_mag = {1'b0, ~sh_raw} + 6'd1;

  always_comb begin
    res   = a;
    c_new = 1'b0;
    l_new = 1'b0;
    f_new = 1'b0;
    case (I_OPCODE)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        res   = sum[MSB:0];
        c_new = sum[DATA_WIDTH];
        f_new = (I_OPCODE != OP_ADDU) && (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        res   = diff[MSB:0];
        c_new = diff[DATA_WIDTH];
        l_new = (a < b);
        f_new = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_LSH, OP_ASH: begin
        if (!sh_raw[4]) begin
          res = a << sh_raw[3:0];
        end else if (sh_mag >= 6'd16) begin
          res = (I_OPCODE == OP_ASH) ? {DATA_WIDTH{a[MSB]}} : '0;
        end else if (I_OPCODE == OP_ASH) begin
          res = $unsigned($signed(a) >>> sh_mag[3:0]);
        end else begin
          res = a >> sh_mag[3:0];
        end
      end
      OP_MOV: res = b;
      OP_LUI: res = {b[7:0], {(DATA_WIDTH-8){1'b0}}};
      default: res = a;
    endcase
  end

  // CMP reports the relation of A and B rather than the raw difference sign.
  assign z_new = (res == '0);
  assign n_new = (I_OPCODE == OP_CMP) ? ($signed(a) < $signed(b)) : res[MSB];

  assign O_WRITE_PORT = I_IMM_SEL ? I_IMMEDIATE : res;

  // Register file: every enabled register loads the same write-back value.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge I_CLK or posedge I_NRESET) begin
      if (I_NRESET)
        regs[i] <= '0;
      else if (I_ENABLE && I_REG_ENABLE[i])
        regs[i] <= O_WRITE_PORT;
    end
  end

  // Flags only track ALU results, never immediate loads.
  always_ff @(posedge I_CLK or posedge I_NRESET) begin
    if (I_NRESET)
      O_FLAGS <= '0;
    else if (I_ENABLE && !I_IMM_SEL) begin
      O_FLAGS[FC] <= c_new;
      O_FLAGS[FL] <= l_new;
      O_FLAGS[FF] <= f_new;
      O_FLAGS[FZ] <= z_new;
      O_FLAGS[FN] <= n_new;
    end
  end

endmodule

// File: tb/tb_cr16_datapath.sv
// tb_cr16_datapath - directed-vector bench for cr16_datapath.
// Stimulus tasks drive inputs just after a rising edge and queue the value
// expected on O_WRITE_PORT (this cycle) or O_FLAGS (after the previous edge);
// a monitor on the falling edge pops and compares everything queued.
module tb_cr16_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] reg_en;
  logic [3:0]  asel, bsel, op;
  logic [15:0] imm;
  logic        imm_sel;
  logic [15:0] wp;
  logic [4:0]  flags;

  localparam logic [3:0] ADD = 4'h0, ADDC = 4'h2, SUBC = 4'h3, SUB = 4'h4,
                         CMP = 4'h5, AND_ = 4'h6, OR_ = 4'h7, XOR_ = 4'h8,
                         NOT_ = 4'h9, LSH = 4'hA, ASH = 4'hB, MOV = 4'hC,
                         LUI = 4'hD, PASS = 4'hE;

  typedef struct {
    string       nm;
    bit          is_flag;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  cr16_datapath dut (
    .I_CLK(clk), .I_NRESET(rst), .I_ENABLE(en), .I_REG_ENABLE(reg_en),
    .I_READ_PORT_A_SEL(asel), .I_READ_PORT_B_SEL(bsel), .I_OPCODE(op),
    .I_IMMEDIATE(imm), .I_IMM_SEL(imm_sel), .O_WRITE_PORT(wp), .O_FLAGS(flags)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = e.is_flag ? {11'b0, flags} : wp;
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
      end
    end
  end

  task automatic exp_wp(input string nm, input logic [15:0] v);
    exp_t e; e.nm = nm; e.is_flag = 1'b0; e.exp = v; q.push_back(e);
  endtask

  task automatic exp_fl(input string nm, input logic [4:0] v);
    exp_t e; e.nm = nm; e.is_flag = 1'b1; e.exp = {11'b0, v}; q.push_back(e);
  endtask

  // One cycle: drive, queue write-port expectation, pass the next edge.
  task automatic cyc(input logic e, input logic [15:0] re, input int a, input int b,
                     input logic [3:0] o, input logic [15:0] im, input logic is,
                     input string nm, input logic [15:0] x);
    en = e; reg_en = re; asel = 4'(a); bsel = 4'(b); op = o; imm = im; imm_sel = is;
    exp_wp(nm, x);
    @(posedge clk); #1;
  endtask

  task automatic wr_imm(input int k, input logic [15:0] v);
    cyc(1'b1, 16'(1 << k), 0, 0, PASS, v, 1'b1, "imm_wp", v);
  endtask

  task automatic rd(input int k, input logic [15:0] v);
    cyc(1'b0, 16'h0, k, 0, PASS, 16'h0, 1'b0, $sformatf("rd_r%0d", k), v);
  endtask

  logic [15:0] fib [14] = '{16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
                            16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987};

  initial begin
    rst = 1'b1; en = 1'b0; reg_en = '0; asel = '0; bsel = '0; op = PASS;
    imm = '0; imm_sel = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    exp_fl("rst_flags", 5'b00000);
    rd(0, 16'h0);
    rd(15, 16'h0);
    rst = 1'b0;

    // Immediate loads
    wr_imm(0, 16'h1);
    rd(0, 16'h1);
    wr_imm(1, 16'h1);
    rd(1, 16'h1);
    rd(0, 16'h1);

    // Fibonacci into R2..R15
    for (int k = 0; k < 14; k++)
      cyc(1'b1, 16'(1 << (k + 2)), k, k + 1, ADD, 16'h0, 1'b0, $sformatf("fib%0d", k), fib[k]);
    exp_fl("fib_flags", 5'b00000);
    rd(15, 16'd987);
    rd(8, 16'd34);

    // Signed / carry boundaries. Flags order {C,L,F,Z,N}.
    wr_imm(0, 16'h0000);
    wr_imm(1, 16'h0001);
    cyc(1'b1, 16'h0004, 0, 1, SUB, 16'h0, 1'b0, "sub_0m1", 16'hFFFF);
    exp_fl("sub_0m1_flags", 5'b11001);
    wr_imm(3, 16'h7FFF);
    exp_fl("imm_holds_flags", 5'b11001);
    cyc(1'b1, 16'h0010, 3, 1, ADD, 16'h0, 1'b0, "add_ovf", 16'h8000);
    exp_fl("add_ovf_flags", 5'b00101);
    cyc(1'b1, 16'h0020, 2, 1, ADD, 16'h0, 1'b0, "add_carry", 16'h0000);
    exp_fl("add_carry_flags", 5'b10010);
    cyc(1'b1, 16'h0000, 0, 1, CMP, 16'h0, 1'b0, "cmp_0_1", 16'hFFFF);
    exp_fl("cmp_0_1_flags", 5'b11001);
    cyc(1'b1, 16'h0000, 1, 1, ADDC, 16'h0, 1'b0, "addc", 16'h0003);
    exp_fl("addc_flags", 5'b00000);
    cyc(1'b1, 16'h0000, 4, 1, CMP, 16'h0, 1'b0, "cmp_8000_1", 16'h7FFF);
    exp_fl("cmp_8000_1_flags", 5'b00101);
    cyc(1'b1, 16'h0000, 0, 1, SUB, 16'h0, 1'b0, "sub_set_c", 16'hFFFF);
    cyc(1'b1, 16'h0000, 3, 1, SUBC, 16'h0, 1'b0, "subc", 16'h7FFD);
    exp_fl("subc_flags", 5'b00000);
    cyc(1'b1, 16'h0000, 0, 3, MOV, 16'h0, 1'b0, "mov", 16'h7FFF);
    cyc(1'b1, 16'h0000, 0, 3, LUI, 16'h0, 1'b0, "lui", 16'hFF00);

    // Boolean ops written to R2..R5 and read back
    wr_imm(0, 16'h0007);
    wr_imm(1, 16'h0004);
    cyc(1'b1, 16'h0004, 0, 1, AND_, 16'h0, 1'b0, "and", 16'h0004);
    cyc(1'b1, 16'h0008, 0, 1, OR_,  16'h0, 1'b0, "or",  16'h0007);
    cyc(1'b1, 16'h0010, 0, 1, XOR_, 16'h0, 1'b0, "xor", 16'h0003);
    cyc(1'b1, 16'h0020, 0, 1, NOT_, 16'h0, 1'b0, "not", 16'hFFF8);
    exp_fl("not_flags", 5'b00001);
    rd(2, 16'h0004);
    rd(3, 16'h0007);
    rd(4, 16'h0003);
    rd(5, 16'hFFF8);

    // Shifts
    wr_imm(0, 16'h0001);
    for (int k = 1; k < 16; k++) begin
      wr_imm(1, 16'(k));
      cyc(1'b1, 16'h0000, 0, 1, LSH, 16'h0, 1'b0, $sformatf("lsh%0d", k), 16'(1 << k));
    end
    wr_imm(2, 16'h8000);
    wr_imm(1, 16'hFFFF);
    cyc(1'b1, 16'h0000, 2, 1, LSH, 16'h0, 1'b0, "lsh_m1", 16'h4000);
    cyc(1'b1, 16'h0000, 2, 1, ASH, 16'h0, 1'b0, "ash_m1", 16'hC000);
    wr_imm(1, 16'h0010);
    cyc(1'b1, 16'h0000, 2, 1, LSH, 16'h0, 1'b0, "lsh_m16", 16'h0000);
    cyc(1'b1, 16'h0000, 2, 1, ASH, 16'h0, 1'b0, "ash_m16", 16'hFFFF);
    exp_fl("ash_m16_flags", 5'b00001);

    // Enable low freezes regs and flags
    cyc(1'b0, 16'hFFFF, 0, 0, PASS, 16'h1234, 1'b1, "dis_imm", 16'h1234);
    cyc(1'b0, 16'hFFFF, 0, 2, SUB, 16'h0, 1'b0, "dis_sub", 16'h8001);
    exp_fl("dis_flags", 5'b00001);
    rd(0, 16'h0001);
    rd(2, 16'h8000);

    // Asynchronous reset between edges
    en = 1'b0; reg_en = '0; asel = 4'd2; op = PASS; imm_sel = 1'b0;
    #1 rst = 1'b1;
    exp_wp("async_rst_rd", 16'h0000);
    exp_fl("async_rst_flags", 5'b00000);
    @(posedge clk); #1;
    // Write attempted while reset held: reset wins
    cyc(1'b1, 16'hFFFF, 0, 0, PASS, 16'h5555, 1'b1, "rst_write_wp", 16'h5555);
    rst = 1'b0;
    rd(0, 16'h0000);
    rd(9, 16'h0000);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
